// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a single
// shared memory port. One transaction is in flight at a time; the winner keeps
// the grant until the memory answers or the wait limit TIMEOUT expires, which
// also raises a sticky timeout_err.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to break I/D ties in favour of
// the port not served last; without it D always wins a tie.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch port
   input  logic        I_mem_read,
   input  logic [15:0] I_mem_address,
   output logic [15:0] I_mem_rdata,
   output logic        I_mem_resp,
   // data port
   input  logic        D_mem_read,
   input  logic        D_mem_write,
   input  logic [15:0] D_mem_address,
   input  logic [15:0] D_mem_wdata,
   input  logic [1:0]  D_mem_byte_enable,
   output logic [15:0] D_mem_rdata,
   output logic        D_mem_resp,
   // shared memory port
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_address,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_rdata,
   input  logic        mem_resp,
   // status
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

   state_t      state_q, state_d;
   port_t       last_grant_q, last_grant_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        timeout_err_q, timeout_err_d;

   logic        d_req, i_req;
   logic        grant_d, grant_i;
   logic [15:0] wait_inc;

   // Arbitration between the two ports; only consulted while IDLE.
   always_comb begin
      d_req = D_mem_read | D_mem_write;
      i_req = I_mem_read;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // On a tie, D wins only if I was the port served most recently.
      grant_d = d_req & (~i_req | (last_grant_q == PORT_I));
`else
      // Fixed priority: any D request beats I.
      grant_d = d_req;
`endif
      grant_i = i_req & ~grant_d;
   end

   // Next-state, grant history, wait counter and sticky error.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = timeout_err_q;
      // In SERVE the counter is always below TIMEOUT, so this cannot wrap.
      wait_inc      = wait_cnt_q + 16'd1;
      unique case (state_q)
         IDLE: begin
            // A stray mem_resp here is simply ignored.
            if (grant_d) begin
               state_d      = SERVE_D;
               last_grant_d = PORT_D;
               wait_cnt_d   = '0;
            end else if (grant_i) begin
               state_d      = SERVE_I;
               last_grant_d = PORT_I;
               wait_cnt_d   = '0;
            end
         end
         SERVE_I, SERVE_D: begin
            // Grant is held until memory answers, even if the port drops its request.
            if (mem_resp) begin
               state_d = IDLE;
            end else if (wait_inc >= TIMEOUT_W) begin
               // Memory went silent: give up without a resp and flag it forever.
               wait_cnt_d    = TIMEOUT_W;
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state registers; reset is asynchronous so a mid-transaction reset drops
   // the grant (and every combinational output below) immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         last_grant_q  <= PORT_I;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Memory-side and port-side outputs steered by the current grant.
   always_comb begin
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_wdata       = '0;
      mem_byte_enable = '0;
      I_mem_resp      = 1'b0;
      D_mem_resp      = 1'b0;
      unique case (state_q)
         SERVE_I: begin
            mem_read    = I_mem_read;
            mem_address = I_mem_address;
            I_mem_resp  = mem_resp;
         end
         SERVE_D: begin
            // Read+write together is treated as a write.
            mem_write       = D_mem_write;
            mem_read        = D_mem_read & ~D_mem_write;
            mem_address     = D_mem_address;
            mem_wdata       = D_mem_wdata;
            mem_byte_enable = D_mem_byte_enable;
            D_mem_resp      = mem_resp;
         end
         default: ;
      endcase
   end

   // Read data is broadcast; the resp tells each port when it is valid.
   assign I_mem_rdata = mem_rdata;
   assign D_mem_rdata = mem_rdata;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam int TO = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // owner encoding used by the model: 0 = nobody, 1 = I, 2 = D
   localparam int NONE = 0;
   localparam int PI   = 1;
   localparam int PD   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        I_mem_read;
   logic [15:0] I_mem_address;
   logic [15:0] I_mem_rdata;
   logic        I_mem_resp;
   logic        D_mem_read, D_mem_write;
   logic [15:0] D_mem_address, D_mem_wdata;
   logic [1:0]  D_mem_byte_enable;
   logic [15:0] D_mem_rdata;
   logic        D_mem_resp;
   logic        mem_read, mem_write;
   logic [15:0] mem_address, mem_wdata;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_rdata;
   logic        mem_resp;
   logic        timeout_err;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model
   int owner, waited, last_srv;
   bit err;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .I_mem_read(I_mem_read), .I_mem_address(I_mem_address),
      .I_mem_rdata(I_mem_rdata), .I_mem_resp(I_mem_resp),
      .D_mem_read(D_mem_read), .D_mem_write(D_mem_write),
      .D_mem_address(D_mem_address), .D_mem_wdata(D_mem_wdata),
      .D_mem_byte_enable(D_mem_byte_enable),
      .D_mem_rdata(D_mem_rdata), .D_mem_resp(D_mem_resp),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner    = NONE;
      waited   = 0;
      last_srv = PI;
      err      = 1'b0;
   endtask

   // One rising edge of the model, from the inputs held across that edge.
   task automatic model_clock();
      int win;
      if (rst) begin
         model_reset();
      end else if (owner == NONE) begin
         win = NONE;
         if ((D_mem_read || D_mem_write) && I_mem_read)
            win = (RR && last_srv == PD) ? PI : PD;
         else if (D_mem_read || D_mem_write)
            win = PD;
         else if (I_mem_read)
            win = PI;
         if (win != NONE) begin
            owner    = win;
            last_srv = win;
            waited   = 0;
         end
      end else if (mem_resp) begin
         owner = NONE;
      end else begin
         waited++;
         if (waited >= TO) begin
            err   = 1'b1;
            owner = NONE;
         end
      end
   endtask

   // Compare every output against what the model expects right now.
   task automatic check_outputs();
      logic        e_rd, e_wr, e_ir, e_dr;
      logic [15:0] e_addr, e_wd;
      logic [1:0]  e_be;
      e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_addr = 0; e_wd = 0; e_be = 0;
      if (owner == PI) begin
         e_rd   = I_mem_read;
         e_addr = I_mem_address;
         e_ir   = mem_resp;
      end else if (owner == PD) begin
         e_wr   = D_mem_write;
         e_rd   = D_mem_read && !D_mem_write;
         e_addr = D_mem_address;
         e_wd   = D_mem_wdata;
         e_be   = D_mem_byte_enable;
         e_dr   = mem_resp;
      end
      chk("mem_read", mem_read, e_rd);
      chk("mem_write", mem_write, e_wr);
      chk("mem_address", mem_address, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("mem_byte_enable", mem_byte_enable, e_be);
      chk("I_mem_resp", I_mem_resp, e_ir);
      chk("D_mem_resp", D_mem_resp, e_dr);
      chk("I_mem_rdata", I_mem_rdata, mem_rdata);
      chk("D_mem_rdata", D_mem_rdata, mem_rdata);
      chk("timeout_err", timeout_err, err);
   endtask

   task automatic settle();
      #1;
      check_outputs();
   endtask

   task automatic advance();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic idle_inputs();
      I_mem_read = 0; I_mem_address = 0;
      D_mem_read = 0; D_mem_write = 0; D_mem_address = 0; D_mem_wdata = 0;
      D_mem_byte_enable = 0; mem_resp = 0; mem_rdata = 0;
   endtask

   initial begin
      int grants[6];
      int ngr;
      int exp_g;

      rst = 1;
      idle_inputs();
      model_reset();

      // reset state
      settle();
      chk("rst_timeout_err", timeout_err, 1'b0);
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_address", mem_address, 16'h0);
      @(negedge clk);
      rst = 0;
      step();

      // single I read, memory answers on the 3rd serve cycle
      I_mem_read = 1; I_mem_address = 16'h3000;
      settle();
      chk("ifetch_not_yet", mem_read, 1'b0);
      advance();
      settle();
      chk("ifetch_mem_read", mem_read, 1'b1);
      chk("ifetch_addr", mem_address, 16'h3000);
      advance();
      step();
      mem_resp = 1; mem_rdata = 16'h1234;
      settle();
      chk("ifetch_I_resp", I_mem_resp, 1'b1);
      chk("ifetch_I_rdata", I_mem_rdata, 16'h1234);
      chk("ifetch_D_resp", D_mem_resp, 1'b0);
      advance();
      I_mem_read = 0; mem_resp = 0;
      settle();
      chk("ifetch_resp_one_cycle", I_mem_resp, 1'b0);
      advance();

      // D write with mask 01, I idle
      D_mem_write = 1; D_mem_address = 16'h4000; D_mem_wdata = 16'hBEEF; D_mem_byte_enable = 2'b01;
      step();
      for (int c = 0; c < 2; c++) begin
         settle();
         chk("dwr_mem_write", mem_write, 1'b1);
         chk("dwr_mask", mem_byte_enable, 2'b01);
         chk("dwr_wdata", mem_wdata, 16'hBEEF);
         advance();
      end
      mem_resp = 1;
      settle();
      chk("dwr_mem_write_last", mem_write, 1'b1);
      chk("dwr_D_resp", D_mem_resp, 1'b1);
      advance();
      D_mem_write = 0; mem_resp = 0;
      settle();
      chk("dwr_resp_one_cycle", D_mem_resp, 1'b0);
      advance();

      // contention: both ports request constantly, memory answers at once
      rst = 1; model_reset();
      step();
      rst = 0;
      I_mem_read = 1; I_mem_address = 16'h1111;
      D_mem_read = 1; D_mem_address = 16'h2222;
      mem_resp = 1;
      ngr = 0;
      for (int c = 0; c < 40 && ngr < 6; c++) begin
         settle();
         if (mem_read) begin
            grants[ngr] = (mem_address == 16'h2222) ? PD : PI;
            ngr++;
         end
         advance();
      end
      chk("arb_grant_count", ngr, 6);
      for (int k = 0; k < 6 && k < ngr; k++) begin
         exp_g = RR ? ((k % 2 == 0) ? PD : PI) : PD;
         chk($sformatf("arb_grant%0d", k), grants[k], exp_g);
      end
      idle_inputs();
      step();

      // asynchronous reset two cycles into a D write
      D_mem_write = 1; D_mem_address = 16'h5000; D_mem_wdata = 16'hA5A5; D_mem_byte_enable = 2'b11;
      step();
      step();
      step();
      rst = 1; model_reset();
      settle();
      chk("arst_mem_write", mem_write, 1'b0);
      chk("arst_D_resp", D_mem_resp, 1'b0);
      advance();
      rst = 0; D_mem_write = 0;
      settle();
      chk("arst_after_mem_write", mem_write, 1'b0);
      advance();

      // timeout: D read never answered, I waiting behind it
      D_mem_read = 1; D_mem_address = 16'h6000;
      I_mem_read = 1; I_mem_address = 16'h7000;
      step();
      for (int c = 0; c < TO; c++) begin
         if (c == TO - 1) D_mem_read = 0;
         settle();
         chk("to_no_err_yet", timeout_err, 1'b0);
         chk("to_addr_is_d", mem_address, 16'h6000);
         chk("to_no_D_resp", D_mem_resp, 1'b0);
         advance();
      end
      settle();
      chk("to_err_set", timeout_err, 1'b1);
      chk("to_back_idle", mem_read, 1'b0);
      advance();
      mem_resp = 1; mem_rdata = 16'h0F0F;
      settle();
      chk("to_I_granted", mem_read, 1'b1);
      chk("to_I_addr", mem_address, 16'h7000);
      chk("to_I_resp", I_mem_resp, 1'b1);
      advance();
      I_mem_read = 0; mem_resp = 0;
      step();
      settle();
      chk("to_err_sticky", timeout_err, 1'b1);
      advance();

      // stray mem_resp while IDLE
      mem_resp = 1;
      settle();
      chk("stray_I_resp", I_mem_resp, 1'b0);
      chk("stray_D_resp", D_mem_resp, 1'b0);
      advance();
      mem_resp = 0;
      settle();
      chk("stray_still_idle", mem_read, 1'b0);
      advance();

      // random traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(63) == 0) begin
            rst = 1;
            model_reset();
         end else begin
            rst = 0;
         end
         I_mem_read        = 1'($urandom_range(1));
         I_mem_address     = 16'($urandom);
         D_mem_read        = 1'($urandom_range(1));
         D_mem_write       = ($urandom_range(2) == 0);
         D_mem_address     = 16'($urandom);
         D_mem_wdata       = 16'($urandom);
         D_mem_byte_enable = 2'($urandom_range(3));
         mem_resp          = ($urandom_range(3) == 0);
         mem_rdata         = 16'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT, default 255, mem_resp wait limit in cycles (1..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 I_mem_read  input  1  instruction-fetch read request.
REQ-005 I_mem_address  input  16 (lc3b_word)  fetch address.
REQ-006 I_mem_rdata / I_mem_resp  output  16 / 1  fetch data; fetch done.
REQ-007 D_mem_read, D_mem_write  input  1 each  data-port requests.
REQ-008 D_mem_address, D_mem_wdata  input  16 each  data address, write data.
REQ-009 D_mem_byte_enable  input  2 (lc3b_mem_wmask)  data write mask.
REQ-010 D_mem_rdata / D_mem_resp  output  16 / 1  data read data; data done.
REQ-011 mem_read, mem_write  output  1 each  shared-memory request.
REQ-012 mem_address, mem_wdata  output  16 each; mem_byte_enable  output  2.
REQ-013 mem_rdata / mem_resp  input  16 / 1  shared-memory data; done.
REQ-014 timeout_err  output  1  sticky: TIMEOUT exceeded.

Function
REQ-015 The FSM SHALL have states IDLE, SERVE_I, SERVE_D.
REQ-016 In IDLE, mem_read = mem_write = 0; both resps = 0.
REQ-017 IDLE -> SERVE_D if D request (read|write) is pending and D wins arbitration; IDLE -> SERVE_I if I_mem_read is pending and I wins; else stay IDLE.
REQ-018 Read and write both asserted on D SHALL be served as a write.
REQ-019 SERVE_x SHALL drive all mem_* outputs combinationally from port x; the other port's request is ignored.
REQ-020 In SERVE_x, mem_rdata SHALL go to x_mem_rdata and mem_resp to x_mem_resp; the other port's resp = 0; I_mem_rdata/D_mem_rdata SHALL always carry mem_rdata.
REQ-021 SERVE_x -> IDLE on the edge where mem_resp = 1; the grant is held until then, even if x drops its request.
REQ-022 Latency: request seen in IDLE at cycle N -> mem request at N+1; resp at cycle M -> earliest next grant at M+2 (one IDLE bubble).
REQ-023 last_grant register SHALL record the port served most recently and update on entry to SERVE_x.
REQ-024 Wait counter SHALL clear on entry to SERVE_x and increment each SERVE cycle without mem_resp, saturating at TIMEOUT.
REQ-025 When the counter reaches TIMEOUT, timeout_err SHALL be set and held until rst, and the FSM SHALL force a return to IDLE without asserting any resp.
REQ-026 mem_resp while in IDLE SHALL be ignored.

Reset
REQ-027 rst SHALL force IDLE immediately (asynchronously), including mid-transaction.
REQ-028 rst SHALL clear the counter and timeout_err to 0 and set last_grant to I.
REQ-029 During and right after rst, all mem_* control outputs and resps SHALL be 0; mem_address/mem_wdata/mem_byte_enable SHALL be 0 in IDLE.

Configuration
REQ-030 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 Defined: on a tie, grant the port not in last_grant.
REQ-032 Undefined: fixed priority, D always wins a tie; last_grant is still maintained.

Verification
REQ-033 Single I read 0x3000; memory responds after 3 cycles with 0x1234 -> I_mem_resp for 1 cycle, I_mem_rdata = 0x1234, D_mem_resp = 0.
REQ-034 D write 0x4000, wdata 0xBEEF, mask 2'b01, with I idle -> mem_write = 1 and mask = 01 for the whole SERVE_D; one D_mem_resp.
REQ-035 I and D requesting every cycle for 6 grants -> without the macro, all grants go to D; with it, grants alternate D,I,D,I,D,I (last_grant = I after reset).
REQ-036 rst asserted 2 cycles into SERVE_D -> mem_write drops to 0 in the same cycle; FSM is IDLE; no resp is issued.
REQ-037 TIMEOUT = 4 and memory never responds -> timeout_err = 1 after 4 SERVE cycles; FSM returns to IDLE; a pending I request is then granted.
REQ-038 Stray mem_resp pulse in IDLE -> no x_mem_resp; state unchanged.
